fix_session_cfg_bank: RTL and testbench
=======================================

// Module: fix_session_cfg_bank
// PURPOSE
//  Multi-session configuration bank for the FIX parser. Holds validated connection parameters
//  for N_SESS sessions. Fields arrive over a field-addressed write interface into a staging
//  set, are range-checked on commit, then atomically copied into the per-session bank.
//  The connection/session logic reads any session through a registered read port.
// PARAMETERS
//  N_SESS       4    number of sessions (>=2); SW = $clog2(N_SESS)
//  VALUE_WIDTH  256  width of senderCompId/targetCompId; multiple of DATA_W
//  WIDTH_SIZE   5    width of sizeSenderId/sizeTargetId
//  DATA_W       32   write-data beat width
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            async active-low reset
//  cfg_start_i     in   1            open staging for session cfg_sess_i
//  cfg_sess_i      in   SW           session index for start/clear
//  cfg_clr_i       in   1            invalidate session cfg_sess_i (IDLE only)
//  cfg_wr_i        in   1            field write strobe
//  cfg_field_i     in   4            field id (map below)
//  cfg_data_i      in   DATA_W       field data, LSB-aligned
//  cfg_commit_i    in   1            request check+commit of staging
//  cfg_busy_o      out  1            high in LOAD/CHECK/COMMIT
//  cfg_done_o      out  1            1-cycle pulse: commit written
//  cfg_err_o       out  1            1-cycle pulse: commit rejected
//  cfg_err_code_o  out  3            code of last rejection, held until next reject
//  sess_valid_o    out  N_SESS       per-session committed-valid flags
//  rd_sess_i       in   SW           read-port session select
//  connectType_o .. sizeTargetId_o  out  (field widths)  registered bank contents for rd_sess_i
// BEHAVIOUR
//  Reset: FSM=IDLE; bank, staging, sess_valid_o, read outputs, err_code=0; done/err/busy low.
//  Field map: 0 connectType[1:0], 1 reconnectInt[7:0], 2 starttime[15:0], 3 endtime[15:0],
//   4 beginstring[5:0], 5 defaultApplVerId[5:0], 6 hostAddr[15:0], 7 heartBeatInt[7:0],
//   8 sizeSenderId, 9 sizeTargetId: take LSBs of cfg_data_i, excess bits ignored.
//   10 senderCompId, 11 targetCompId: shift-in, stg <= {stg[VALUE_WIDTH-DATA_W-1:0], data},
//   MS beat first; VALUE_WIDTH/DATA_W beats fill it; extra beats shift out oldest data.
//   Ids 12-15: write ignored, sets sticky bad_field flag.
//  FSM: IDLE -> LOAD on cfg_start_i (latch session, zero staging, clear bad_field).
//   LOAD: cfg_wr_i applies write; cfg_commit_i -> CHECK. Same-cycle wr+commit: write applied
//   first, CHECK sees it. cfg_start_i in LOAD restarts: new session latched, staging zeroed;
//   start has priority over commit in the same cycle.
//   CHECK (1 cycle): first failing rule in priority order -> IDLE, cfg_err_o pulses next
//   cycle, err_code set; all pass -> COMMIT.
//   Rules: 1 bad_field; 2 heartBeatInt==0; 3 starttime==endtime; 4 connectType==2'b11;
//   5 sizeSenderId==0 or sizeTargetId==0.
//   COMMIT (1 cycle): bank[sess] <= staging, sess_valid[sess] <= 1 -> IDLE; cfg_done_o pulses
//   next cycle. Commit accepted at edge E0 -> CHECK -> COMMIT -> done high after edge E3.
//  Rejected commit leaves bank and sess_valid unchanged (old config stays live).
//  IDLE: cfg_wr_i/cfg_commit_i ignored; cfg_clr_i clears sess_valid[cfg_sess_i] (bank kept);
//   cfg_start_i+cfg_clr_i same cycle: clear applied, then LOAD entered.
//  cfg_start_i/cfg_clr_i ignored in CHECK/COMMIT.
//  Read port: outputs <= bank[rd_sess_i] each cycle, 1-cycle latency; a read of the
//   session being committed returns new data from the cycle after the bank write.
//  Async reset mid-LOAD/CHECK/COMMIT: aborts, all state cleared, no done/err pulse.
// TESTING
//  Reset: rst_n low mid-LOAD -> IDLE, busy=0, sess_valid=0, read outputs 0.
//  Start s2, write hb=30, start=0x0900, end=0x1700, sizes 8/8, 8 beats 0x11..0x88, commit ->
//   done 3 cycles after commit; rd_sess=2 -> senderCompId=0x11..88, sess_valid=4'b0100.
//  Valid commit to s1, then start s1 with hb=0, commit -> err, code=2; s1 keeps old values.
//  Write field 13 then commit -> err code=1 (beats heartBeatInt==0 rule).
//  Same-cycle wr(field7, 5)+commit -> passes with heartBeatInt=5; restart in LOAD to s3 ->
//   staging zeroed, commit lands only in s3.
//  IDLE cfg_clr_i s2 -> sess_valid[2]=0, bank data unchanged; wr/commit in IDLE -> no effect.

Source files
------------

// File: rtl/fix_session_cfg_bank.sv
// ---------------------------------------------------------------------------
// fix_session_cfg_bank
//   Configuration bank holding validated connection parameters for N_SESS
//   FIX sessions. Software opens a staging set for one session, writes
//   fields by id, then requests a commit. The staging set is range-checked
//   for one cycle and, if every rule passes, copied atomically into that
//   session's bank entry. A rejected commit leaves the live entry untouched.
//   The connection logic reads any entry through a registered read port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_start_i / cfg_sess_i   open (or restart) staging for a session
//   cfg_clr_i                  invalidate session cfg_sess_i (IDLE only)
//   cfg_wr_i / cfg_field_i /
//   cfg_data_i                 field-addressed staging write
//   cfg_commit_i               request check + commit of the staging set
//   cfg_busy_o                 high while a configuration is in progress
//   cfg_done_o / cfg_err_o     one-cycle result pulses
//   cfg_err_code_o             code of the most recent rejection
//   sess_valid_o               per-session committed-valid flags
//   rd_sess_i                  read-port session select
//   connectType_o ..
//   targetCompId_o             registered bank contents for rd_sess_i
// ---------------------------------------------------------------------------
module fix_session_cfg_bank #(
    parameter int N_SESS      = 4,
    parameter int VALUE_WIDTH = 256,
    parameter int WIDTH_SIZE  = 5,
    parameter int DATA_W      = 32,
    localparam int SW         = $clog2(N_SESS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start_i,
    input  logic [SW-1:0]          cfg_sess_i,
    input  logic                   cfg_clr_i,
    input  logic                   cfg_wr_i,
    input  logic [3:0]             cfg_field_i,
    input  logic [DATA_W-1:0]      cfg_data_i,
    input  logic                   cfg_commit_i,
    output logic                   cfg_busy_o,
    output logic                   cfg_done_o,
    output logic                   cfg_err_o,
    output logic [2:0]             cfg_err_code_o,
    output logic [N_SESS-1:0]      sess_valid_o,
    input  logic [SW-1:0]          rd_sess_i,
    output logic [1:0]             connectType_o,
    output logic [7:0]             reconnectInt_o,
    output logic [15:0]            starttime_o,
    output logic [15:0]            endtime_o,
    output logic [5:0]             beginstring_o,
    output logic [5:0]             defaultApplVerId_o,
    output logic [15:0]            hostAddr_o,
    output logic [7:0]             heartBeatInt_o,
    output logic [WIDTH_SIZE-1:0]  sizeSenderId_o,
    output logic [WIDTH_SIZE-1:0]  sizeTargetId_o,
    output logic [VALUE_WIDTH-1:0] senderCompId_o,
    output logic [VALUE_WIDTH-1:0] targetCompId_o
);

    typedef struct packed {
        logic [1:0]             connect_type;
        logic [7:0]             reconnect_int;
        logic [15:0]            start_time;
        logic [15:0]            end_time;
        logic [5:0]             begin_string;
        logic [5:0]             default_appl_ver_id;
        logic [15:0]            host_addr;
        logic [7:0]             heart_beat_int;
        logic [WIDTH_SIZE-1:0]  size_sender_id;
        logic [WIDTH_SIZE-1:0]  size_target_id;
        logic [VALUE_WIDTH-1:0] sender_comp_id;
        logic [VALUE_WIDTH-1:0] target_comp_id;
    } cfg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT
    } state_e;

    // Rejection codes, listed in rule-priority order.
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BAD_FIELD = 3'd1;
    localparam logic [2:0] ERR_HB_ZERO   = 3'd2;
    localparam logic [2:0] ERR_TIME_EQ   = 3'd3;
    localparam logic [2:0] ERR_CONN_TYPE = 3'd4;
    localparam logic [2:0] ERR_SIZE_ZERO = 3'd5;

    state_e            state_q, state_d;
    logic [SW-1:0]     sess_q, sess_d;
    cfg_t              stg_q, stg_d;
    logic              bad_q, bad_d;
    logic [N_SESS-1:0] valid_q, valid_d;
    logic              bank_we;
    cfg_t              bank_q [N_SESS];
    cfg_t              rd_q;
    logic [2:0]        chk_code;

    // Result pulses are delayed one cycle past the bank write so that they
    // line up with the read port already presenting the freshly written entry.
    logic              done_pend_q, done_q;
    logic              err_pend_q, err_q;
    logic [2:0]        code_pend_q, err_code_q;

    // Commit rules, evaluated on the registered staging set in CHECK.
    always_comb begin
        if (bad_q)                                    chk_code = ERR_BAD_FIELD;
        else if (stg_q.heart_beat_int == '0)          chk_code = ERR_HB_ZERO;
        else if (stg_q.start_time == stg_q.end_time)  chk_code = ERR_TIME_EQ;
        else if (stg_q.connect_type == 2'b11)         chk_code = ERR_CONN_TYPE;
        else if (stg_q.size_sender_id == '0 ||
                 stg_q.size_target_id == '0)          chk_code = ERR_SIZE_ZERO;
        else                                          chk_code = ERR_NONE;
    end

    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        sess_d  = sess_q;
        stg_d   = stg_q;
        bad_d   = bad_q;
        valid_d = valid_q;
        bank_we = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Clear is applied even when start arrives in the same cycle.
                if (cfg_clr_i) valid_d[cfg_sess_i] = 1'b0;
                if (cfg_start_i) begin
                    state_d = S_LOAD;
                    sess_d  = cfg_sess_i;
                    stg_d   = '0;
                    bad_d   = 1'b0;
                end
            end
            S_LOAD: begin
                // A restart wins over both a write and a commit.
                if (cfg_start_i) begin
                    sess_d = cfg_sess_i;
                    stg_d  = '0;
                    bad_d  = 1'b0;
                end else begin
                    if (cfg_wr_i) begin
                        unique case (cfg_field_i)
                            4'd0:  stg_d.connect_type        = cfg_data_i[1:0];
                            4'd1:  stg_d.reconnect_int       = cfg_data_i[7:0];
                            4'd2:  stg_d.start_time          = cfg_data_i[15:0];
                            4'd3:  stg_d.end_time            = cfg_data_i[15:0];
                            4'd4:  stg_d.begin_string        = cfg_data_i[5:0];
                            4'd5:  stg_d.default_appl_ver_id = cfg_data_i[5:0];
                            4'd6:  stg_d.host_addr           = cfg_data_i[15:0];
                            4'd7:  stg_d.heart_beat_int      = cfg_data_i[7:0];
                            4'd8:  stg_d.size_sender_id      = cfg_data_i[WIDTH_SIZE-1:0];
                            4'd9:  stg_d.size_target_id      = cfg_data_i[WIDTH_SIZE-1:0];
                            // Ids are shifted in most-significant beat first;
                            // surplus beats push the oldest data out the top.
                            4'd10: stg_d.sender_comp_id =
                                       (stg_q.sender_comp_id << DATA_W) | VALUE_WIDTH'(cfg_data_i);
                            4'd11: stg_d.target_comp_id =
                                       (stg_q.target_comp_id << DATA_W) | VALUE_WIDTH'(cfg_data_i);
                            default: bad_d = 1'b1;
                        endcase
                    end
                    // The commit sees a same-cycle write because CHECK reads stg_q.
                    if (cfg_commit_i) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = (chk_code != ERR_NONE) ? S_IDLE : S_COMMIT;
            end
            S_COMMIT: begin
                bank_we          = 1'b1;
                valid_d[sess_q]  = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sess_q      <= '0;
            stg_q       <= '0;
            bad_q       <= 1'b0;
            valid_q     <= '0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            code_pend_q <= '0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            sess_q      <= sess_d;
            stg_q       <= stg_d;
            bad_q       <= bad_d;
            valid_q     <= valid_d;
            done_pend_q <= (state_q == S_COMMIT);
            done_q      <= done_pend_q;
            err_pend_q  <= (state_q == S_CHECK) && (chk_code != ERR_NONE);
            err_q       <= err_pend_q;
            if ((state_q == S_CHECK) && (chk_code != ERR_NONE)) code_pend_q <= chk_code;
            if (err_pend_q) err_code_q <= code_pend_q;
        end
    end

    // NOTE: the bank is a register array, so it can and does take the reset;
    // a session read before its first commit must return zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SESS; i++) bank_q[i] <= '0;
            rd_q <= '0;
        end else begin
            if (bank_we) bank_q[sess_q] <= stg_q;
            rd_q <= bank_q[rd_sess_i];
        end
    end

    assign cfg_busy_o         = (state_q != S_IDLE);
    assign cfg_done_o         = done_q;
    assign cfg_err_o          = err_q;
    assign cfg_err_code_o     = err_code_q;
    assign sess_valid_o       = valid_q;

    assign connectType_o      = rd_q.connect_type;
    assign reconnectInt_o     = rd_q.reconnect_int;
    assign starttime_o        = rd_q.start_time;
    assign endtime_o          = rd_q.end_time;
    assign beginstring_o      = rd_q.begin_string;
    assign defaultApplVerId_o = rd_q.default_appl_ver_id;
    assign hostAddr_o         = rd_q.host_addr;
    assign heartBeatInt_o     = rd_q.heart_beat_int;
    assign sizeSenderId_o     = rd_q.size_sender_id;
    assign sizeTargetId_o     = rd_q.size_target_id;
    assign senderCompId_o     = rd_q.sender_comp_id;
    assign targetCompId_o     = rd_q.target_comp_id;

endmodule

// File: tb/tb_fix_session_cfg_bank.sv
// ---------------------------------------------------------------------------
// tb_fix_session_cfg_bank
//   Self-checking bench for fix_session_cfg_bank: directed corner cases,
//   a table of rule vectors, and a randomized phase compared against a
//   field-array reference model of the staging set and bank.
// ---------------------------------------------------------------------------
module tb_fix_session_cfg_bank;

    localparam int N_SESS = 4;
    localparam int NF     = 12;
    localparam int FW [NF] = '{2, 8, 16, 16, 6, 6, 16, 8, 5, 5, 256, 256};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_start_i, cfg_clr_i, cfg_wr_i, cfg_commit_i;
    logic [1:0]   cfg_sess_i, rd_sess_i;
    logic [3:0]   cfg_field_i;
    logic [31:0]  cfg_data_i;
    logic         cfg_busy_o, cfg_done_o, cfg_err_o;
    logic [2:0]   cfg_err_code_o;
    logic [3:0]   sess_valid_o;
    logic [1:0]   connectType_o;
    logic [7:0]   reconnectInt_o, heartBeatInt_o;
    logic [15:0]  starttime_o, endtime_o, hostAddr_o;
    logic [5:0]   beginstring_o, defaultApplVerId_o;
    logic [4:0]   sizeSenderId_o, sizeTargetId_o;
    logic [255:0] senderCompId_o, targetCompId_o;

    fix_session_cfg_bank dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_start_i        (cfg_start_i),
        .cfg_sess_i         (cfg_sess_i),
        .cfg_clr_i          (cfg_clr_i),
        .cfg_wr_i           (cfg_wr_i),
        .cfg_field_i        (cfg_field_i),
        .cfg_data_i         (cfg_data_i),
        .cfg_commit_i       (cfg_commit_i),
        .cfg_busy_o         (cfg_busy_o),
        .cfg_done_o         (cfg_done_o),
        .cfg_err_o          (cfg_err_o),
        .cfg_err_code_o     (cfg_err_code_o),
        .sess_valid_o       (sess_valid_o),
        .rd_sess_i          (rd_sess_i),
        .connectType_o      (connectType_o),
        .reconnectInt_o     (reconnectInt_o),
        .starttime_o        (starttime_o),
        .endtime_o          (endtime_o),
        .beginstring_o      (beginstring_o),
        .defaultApplVerId_o (defaultApplVerId_o),
        .hostAddr_o         (hostAddr_o),
        .heartBeatInt_o     (heartBeatInt_o),
        .sizeSenderId_o     (sizeSenderId_o),
        .sizeTargetId_o     (sizeTargetId_o),
        .senderCompId_o     (senderCompId_o),
        .targetCompId_o     (targetCompId_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fields kept as a plain array indexed by field id.
    logic [255:0] m_stg  [NF];
    logic [255:0] m_bank [N_SESS][NF];
    logic         m_bad;
    logic         m_load;
    int           m_sess;
    logic [3:0]   m_valid;
    logic [2:0]   m_last_code;

    typedef struct {
        logic [31:0] hb, st, en, ct, ss, ts;
        bit          bad;
        int          code;
    } vec_t;
    vec_t tbl [12];

    localparam logic [255:0] IDS_11_88 =
        256'h00000011_00000022_00000033_00000044_00000055_00000066_00000077_00000088;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [87:0] out_scalars();
        return {connectType_o, reconnectInt_o, starttime_o, endtime_o, beginstring_o,
                defaultApplVerId_o, hostAddr_o, heartBeatInt_o, sizeSenderId_o, sizeTargetId_o};
    endfunction

    function automatic logic [87:0] model_scalars(input int s);
        return {m_bank[s][0][1:0], m_bank[s][1][7:0], m_bank[s][2][15:0], m_bank[s][3][15:0],
                m_bank[s][4][5:0], m_bank[s][5][5:0], m_bank[s][6][15:0], m_bank[s][7][7:0],
                m_bank[s][8][4:0], m_bank[s][9][4:0]};
    endfunction

    task automatic m_reset();
        for (int s = 0; s < N_SESS; s++)
            for (int f = 0; f < NF; f++) m_bank[s][f] = '0;
        for (int f = 0; f < NF; f++) m_stg[f] = '0;
        m_bad = 1'b0; m_load = 1'b0; m_sess = 0; m_valid = '0; m_last_code = '0;
    endtask

    task automatic m_start(input int s);
        m_load = 1'b1;
        m_sess = s;
        m_bad  = 1'b0;
        for (int f = 0; f < NF; f++) m_stg[f] = '0;
    endtask

    task automatic m_write(input logic [3:0] f, input logic [31:0] d);
        int fi;
        fi = int'(f);
        if (!m_load) return;
        if (fi >= NF)      m_bad = 1'b1;
        else if (fi >= 10) m_stg[fi] = (m_stg[fi] << 32) | 256'(d);
        else               m_stg[fi] = 256'(d) & ((256'd1 << FW[fi]) - 256'd1);
    endtask

    function automatic int m_code();
        if (m_bad)                            return 1;
        if (m_stg[7] == 0)                    return 2;
        if (m_stg[2] == m_stg[3])             return 3;
        if (m_stg[0] == 3)                    return 4;
        if (m_stg[8] == 0 || m_stg[9] == 0)   return 5;
        return 0;
    endfunction

    task automatic do_start(input int s, input bit clr);
        cfg_start_i = 1'b1; cfg_clr_i = clr; cfg_sess_i = 2'(s);
        if (clr && !m_load) m_valid[s] = 1'b0;
        m_start(s);
        step();
        cfg_start_i = 1'b0; cfg_clr_i = 1'b0;
    endtask

    task automatic do_clr(input int s);
        cfg_clr_i = 1'b1; cfg_sess_i = 2'(s);
        if (!m_load) m_valid[s] = 1'b0;
        step();
        cfg_clr_i = 1'b0;
    endtask

    task automatic do_wr(input logic [3:0] f, input logic [31:0] d);
        cfg_wr_i = 1'b1; cfg_field_i = f; cfg_data_i = d;
        m_write(f, d);
        step();
        cfg_wr_i = 1'b0;
    endtask

    // Drives a commit (optionally with a same-cycle write or start), then
    // watches six cycles for the response. obs: 0 done, >0 error code, -1 none.
    task automatic commit_op(input bit wr, input logic [3:0] f, input logic [31:0] d,
                             input bit st, input int s, output int obs);
        int exp, lat, pulses;
        cfg_commit_i = 1'b1;
        cfg_wr_i = wr; cfg_field_i = f; cfg_data_i = d;
        cfg_start_i = st; cfg_sess_i = 2'(s);
        exp = -1;
        if (st) begin
            m_start(s);
        end else begin
            if (wr) m_write(f, d);
            if (m_load) begin
                exp = m_code();
                if (exp == 0) begin
                    for (int k = 0; k < NF; k++) m_bank[m_sess][k] = m_stg[k];
                    m_valid[m_sess] = 1'b1;
                end else begin
                    m_last_code = 3'(exp);
                end
                m_load = 1'b0;
            end
        end
        obs = -1; lat = 0; pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                cfg_commit_i = 1'b0; cfg_wr_i = 1'b0; cfg_start_i = 1'b0;
            end
            if (cfg_done_o || cfg_err_o) begin
                pulses++;
                if (lat == 0) begin
                    lat = i - 1;
                    obs = cfg_done_o ? 0 : int'(cfg_err_code_o);
                end
            end
        end
        if (exp < 0) begin
            check("no_response", pulses, 0);
        end else begin
            check("resp_pulses", pulses, 1);
            check("resp_kind", obs, exp);
            check("resp_latency", lat, (exp == 0) ? 3 : 2);
        end
        check("err_code_held", cfg_err_code_o, m_last_code);
        check("busy_after", cfg_busy_o, m_load);
    endtask

    task automatic check_sess(input int s);
        rd_sess_i = 2'(s);
        step();
        check("rd_scalars", out_scalars(), model_scalars(s));
        check("rd_sender", senderCompId_o, m_bank[s][10]);
        check("rd_target", targetCompId_o, m_bank[s][11]);
        check("sess_valid", sess_valid_o, m_valid);
    endtask

    task automatic load_cfg(input int s, input logic [31:0] hb);
        do_start(s, 1'b0);
        do_wr(4'd7, hb);
        do_wr(4'd2, 32'd100 + 32'(s));
        do_wr(4'd3, 32'd200);
        do_wr(4'd8, 32'd3);
        do_wr(4'd9, 32'd4);
        do_wr(4'd0, 32'd1);
        do_wr(4'd6, 32'hA000 + 32'(s));
        do_wr(4'd11, 32'hCAFE0000 + 32'(s));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, cfg_busy_o, 1'b0);
        check({tag, "_valid"}, sess_valid_o, 4'b0000);
        check({tag, "_pulses"}, {cfg_done_o, cfg_err_o}, 2'b00);
        check({tag, "_rd"}, {out_scalars(), senderCompId_o | targetCompId_o}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs;
        tbl[0]  = '{32'd30,  32'h0900,  32'h1700, 32'd1, 32'd8,  32'd8,  1'b0, 0};
        tbl[1]  = '{32'd0,   32'h0900,  32'h1700, 32'd1, 32'd8,  32'd8,  1'b0, 2};
        tbl[2]  = '{32'd0,   32'h0900,  32'h1700, 32'd1, 32'd8,  32'd8,  1'b1, 1};
        tbl[3]  = '{32'd5,   32'h0100,  32'h0100, 32'd1, 32'd8,  32'd8,  1'b0, 3};
        tbl[4]  = '{32'd5,   32'd1,     32'd2,    32'd3, 32'd8,  32'd8,  1'b0, 4};
        tbl[5]  = '{32'd5,   32'd1,     32'd2,    32'd0, 32'd0,  32'd8,  1'b0, 5};
        tbl[6]  = '{32'd5,   32'd1,     32'd2,    32'd3, 32'd8,  32'd0,  1'b0, 4};
        tbl[7]  = '{32'd0,   32'd1,     32'd1,    32'd3, 32'd0,  32'd0,  1'b0, 2};
        tbl[8]  = '{32'd5,   32'd1,     32'd2,    32'd2, 32'd32, 32'd8,  1'b0, 5};
        tbl[9]  = '{32'd256, 32'd1,     32'd2,    32'd0, 32'd1,  32'd1,  1'b0, 2};
        tbl[10] = '{32'd5,   32'h10001, 32'd1,    32'd0, 32'd1,  32'd1,  1'b0, 3};
        tbl[11] = '{32'd255, 32'd0,     32'hFFFF, 32'd2, 32'd31, 32'd31, 1'b0, 0};

        rst_n = 1'b0;
        cfg_start_i = 0; cfg_clr_i = 0; cfg_wr_i = 0; cfg_commit_i = 0;
        cfg_sess_i = 0; cfg_field_i = 0; cfg_data_i = 0; rd_sess_i = 0;
        m_reset();
        #12;
        check_reset_state("por");
        check("por_err_code", cfg_err_code_o, 3'd0);
        #5 rst_n = 1'b1;
        step();

        // Full configuration of session 2 with an 8-beat sender id.
        do_start(2, 1'b0);
        do_wr(4'd7, 32'd30);
        do_wr(4'd2, 32'h0900);
        do_wr(4'd3, 32'h1700);
        do_wr(4'd8, 32'd8);
        do_wr(4'd9, 32'd8);
        for (int k = 1; k <= 8; k++) do_wr(4'd10, 32'h11 * 32'(k));
        commit_op(1'b0, 4'd0, 32'd0, 1'b0, 0, obs);
        check("s2_done", obs, 0);
        check_sess(2);
        check("s2_sender", senderCompId_o, IDS_11_88);
        check("s2_valid", sess_valid_o, 4'b0100);

        // A rejected commit leaves the previous session-1 config live.
        load_cfg(1, 32'd10);
        commit_op(1'b0, 4'd0, 32'd0, 1'b0, 0, obs);
        load_cfg(1, 32'd0);
        commit_op(1'b0, 4'd0, 32'd0, 1'b0, 0, obs);
        check("s1_reject_code", obs, 2);
        check_sess(1);
        check("s1_hb_kept", heartBeatInt_o, 8'd10);

        // Rule table, all on session 0.
        for (int i = 0; i < 12; i++) begin
            do_start(0, 1'b0);
            if (tbl[i].bad) do_wr(4'd13, 32'd0);
            do_wr(4'd0, tbl[i].ct);
            do_wr(4'd7, tbl[i].hb);
            do_wr(4'd2, tbl[i].st);
            do_wr(4'd3, tbl[i].en);
            do_wr(4'd8, tbl[i].ss);
            do_wr(4'd9, tbl[i].ts);
            commit_op(1'b0, 4'd0, 32'd0, 1'b0, 0, obs);
            check($sformatf("vec%0d_code", i), obs, tbl[i].code);
        end
        check_sess(0);

        // Same-cycle write and commit: the commit sees the write.
        do_start(0, 1'b0);
        do_wr(4'd2, 32'd1);
        do_wr(4'd3, 32'd2);
        do_wr(4'd8, 32'd1);
        do_wr(4'd9, 32'd1);
        commit_op(1'b1, 4'd7, 32'd5, 1'b0, 0, obs);
        check("wr_commit_done", obs, 0);
        check_sess(0);
        check("wr_commit_hb", heartBeatInt_o, 8'd5);

        // Restart in LOAD: start beats commit, staging is zeroed.
        do_start(0, 1'b0);
        do_wr(4'd6, 32'hBEEF);
        do_wr(4'd7, 32'd9);
        commit_op(1'b0, 4'd0, 32'd0, 1'b1, 3, obs);
        check("restart_no_commit", obs, -1);
        do_wr(4'd7, 32'd7);
        do_wr(4'd2, 32'd1);
        do_wr(4'd3, 32'd2);
        do_wr(4'd8, 32'd1);
        do_wr(4'd9, 32'd1);
        commit_op(1'b0, 4'd0, 32'd0, 1'b0, 0, obs);
        check_sess(3);
        check("restart_host", hostAddr_o, 16'h0000);
        check_sess(0);

        // IDLE clear keeps data; IDLE write/commit do nothing.
        do_clr(2);
        check_sess(2);
        check("clr_keeps_data", senderCompId_o, IDS_11_88);
        check("clr_valid", sess_valid_o[2], 1'b0);
        do_wr(4'd7, 32'd99);
        commit_op(1'b0, 4'd0, 32'd0, 1'b0, 0, obs);
        check_sess(2);

        // Randomized phase.
        for (int it = 0; it < 60; it++) begin
            int s, nw;
            logic [3:0]  f;
            logic [31:0] d;
            s = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) do_clr(int'($urandom_range(0, 3)));
            do_start(s, $urandom_range(0, 3) == 0);
            nw = int'($urandom_range(4, 16));
            for (int w = 0; w < nw; w++) begin
                f = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
                d = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 3));
                do_wr(f, d);
            end
            f = 4'($urandom_range(0, 11));
            d = 32'($urandom);
            commit_op($urandom_range(0, 1) == 1, f, d, 1'b0, 0, obs);
            check_sess(int'($urandom_range(0, 3)));
        end

        // Reset mid-LOAD.
        do_start(1, 1'b0);
        do_wr(4'd7, 32'd3);
        rst_n = 1'b0;
        #2;
        m_reset();
        check_reset_state("rst_load");
        rst_n = 1'b1;
        step();

        // Reset mid-CHECK: no pulse afterwards, nothing committed.
        load_cfg(2, 32'd20);
        cfg_commit_i = 1'b1;
        step();
        cfg_commit_i = 1'b0;
        rst_n = 1'b0;
        #2;
        m_reset();
        check_reset_state("rst_check");
        rst_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (cfg_done_o || cfg_err_o) pulses++;
            end
            check("rst_no_pulse", pulses, 0);
        end
        check_sess(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
